// File: rtl/enc_pkg.sv
// Shared widths, state encodings and packet type for the AV1 encoder input scheduler.
package enc_pkg;

    localparam int unsigned RANGE_WIDTH  = 16;
    localparam int unsigned SYMBOL_WIDTH = 4;
    localparam int unsigned NSYMS_WIDTH  = SYMBOL_WIDTH + 1;
    localparam int unsigned NSYMS_MIN    = 2;
    localparam int unsigned NSYMS_MAX    = 16;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_RUN   = 2'd1,
        SCH_DRAIN = 2'd2,
        SCH_FINAL = 2'd3
    } sch_state_e;

    typedef struct packed {
        logic [RANGE_WIDTH-1:0]  fl;
        logic [RANGE_WIDTH-1:0]  fh;
        logic [SYMBOL_WIDTH-1:0] symbol;
        logic [NSYMS_WIDTH-1:0]  nsyms;
        logic                    is_bool;
        logic                    last;
    } sym_pkt_t;

    // A packet is well formed when its symbol index fits its alphabet.
    function automatic logic pkt_ok(input sym_pkt_t p);
        logic ok;
        if (p.is_bool) begin
            ok = (p.symbol <= SYMBOL_WIDTH'(1));
        end else begin
            ok = (p.nsyms >= NSYMS_WIDTH'(NSYMS_MIN))
              && (p.nsyms <= NSYMS_WIDTH'(NSYMS_MAX))
              && (NSYMS_WIDTH'(p.symbol) < p.nsyms);
        end
        return ok;
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous packet FIFO; pointers carry a wrap bit so full/empty are exact.
module sched_fifo
    import enc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     wr_en_i,
    input  sym_pkt_t wr_data_i,
    input  logic     rd_en_i,
    output sym_pkt_t rd_data_c_o,
    output logic     ready_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    sym_pkt_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ready_q, empty_q;
    logic            do_push, do_pop;
    logic            full_d, empty_d;

    assign do_push = wr_en_i & ready_q;
    assign do_pop  = rd_en_i & ~empty_q;

    // Next pointers and the flags they imply, so ready/empty come straight from flops.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW])
                && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    // Pointer and flag registers; ready stays low while reset is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ~full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_ptr_q[AW-1:0]];
    assign ready_o     = ready_q;
    assign empty_o     = empty_q;

endmodule

// File: rtl/stage_1_scheduler.sv
// Input scheduler for the arithmetic-encoder pipeline: buffer, check, issue, drain, flush.
module stage_1_scheduler
    import enc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIPE_DEPTH = 4
) (
    input  logic                    general_clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [NSYMS_WIDTH-1:0]  in_nsyms,
    input  logic                    in_bool,
    input  logic                    in_last,
    input  logic                    pipe_stall,
    output logic [RANGE_WIDTH-1:0]  s1_fl,
    output logic [RANGE_WIDTH-1:0]  s1_fh,
    output logic [SYMBOL_WIDTH-1:0] s1_symbol,
    output logic [NSYMS_WIDTH-1:0]  s1_nsyms,
    output logic                    s1_bool,
    output logic                    s1_valid,
    output logic [PIPE_DEPTH-1:0]   pipe_valid,
    output logic                    final_flag,
    output logic                    busy,
    output logic                    err_nsyms
);

    sym_pkt_t                wr_pkt;
    sym_pkt_t                rd_pkt;
    logic                    fifo_empty;
    logic                    pop_c, pkt_ok_c, issue_c, drain_done_c;
    logic [PIPE_DEPTH-1:0]   pv_q, pv_shift_c;
    sch_state_e              state_q;
    logic [RANGE_WIDTH-1:0]  s1_fl_q, s1_fh_q;
    logic [SYMBOL_WIDTH-1:0] s1_symbol_q;
    logic [NSYMS_WIDTH-1:0]  s1_nsyms_q;
    logic                    s1_bool_q, s1_valid_q, final_flag_q, err_q;

    // Pack the upstream fields into a FIFO entry.
    always_comb begin
        wr_pkt.fl      = in_fl;
        wr_pkt.fh      = in_fh;
        wr_pkt.symbol  = in_symbol;
        wr_pkt.nsyms   = in_nsyms;
        wr_pkt.is_bool = in_bool;
        wr_pkt.last    = in_last;
    end

    sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (general_clk),
        .rst_ni      (reset),
        .wr_en_i     (in_valid),
        .wr_data_i   (wr_pkt),
        .rd_en_i     (pop_c),
        .rd_data_c_o (rd_pkt),
        .ready_o     (in_ready),
        .empty_o     (fifo_empty)
    );

    // Pop/issue decision: one packet per unstalled RUN cycle; malformed ones are dropped.
    assign pop_c    = (state_q == SCH_RUN) && !pipe_stall && !fifo_empty;
    assign pkt_ok_c = pkt_ok(rd_pkt);
    assign issue_c  = pop_c & pkt_ok_c;

    // Occupancy after this edge when not stalled; bit0 is stage_1.
    if (PIPE_DEPTH == 1) begin : g_pipe_one
        assign pv_shift_c = issue_c;
    end else begin : g_pipe_many
        assign pv_shift_c = {pv_q[PIPE_DEPTH-2:0], issue_c};
    end

    // Drain completes on the edge where the last occupied stage retires.
    assign drain_done_c = !pipe_stall && (pv_shift_c == '0);

    // Stage_1 input registers; they hold their value when nothing issues.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            s1_fl_q     <= '0;
            s1_fh_q     <= '0;
            s1_symbol_q <= '0;
            s1_nsyms_q  <= '0;
            s1_bool_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
        end else begin
            s1_valid_q <= issue_c;
            if (issue_c) begin
                s1_fl_q     <= rd_pkt.fl;
                s1_fh_q     <= rd_pkt.fh;
                s1_symbol_q <= rd_pkt.symbol;
                s1_nsyms_q  <= rd_pkt.is_bool ? NSYMS_WIDTH'(NSYMS_MIN) : rd_pkt.nsyms;
                s1_bool_q   <= rd_pkt.is_bool;
            end
        end
    end

    // Occupancy shift register, frozen by downstream stall.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
        end else if (!pipe_stall) begin
            pv_q <= pv_shift_c;
        end
    end

    // Sticky malformed-packet flag.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (pop_c && !pkt_ok_c) begin
            err_q <= 1'b1;
        end
    end

    // Stream FSM with registered flush pulse.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SCH_IDLE;
            final_flag_q <= 1'b0;
        end else begin
            final_flag_q <= 1'b0;
            case (state_q)
                SCH_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= SCH_RUN;
                    end
                end
                SCH_RUN: begin
                    if (pop_c && rd_pkt.last) begin
                        state_q <= SCH_DRAIN;
                    end
                end
                SCH_DRAIN: begin
                    if (drain_done_c) begin
                        state_q      <= SCH_FINAL;
                        final_flag_q <= 1'b1;
                    end
                end
                SCH_FINAL: begin
                    state_q <= SCH_IDLE;
                end
                default: begin
                    state_q <= SCH_IDLE;
                end
            endcase
        end
    end

    assign s1_fl      = s1_fl_q;
    assign s1_fh      = s1_fh_q;
    assign s1_symbol  = s1_symbol_q;
    assign s1_nsyms   = s1_nsyms_q;
    assign s1_bool    = s1_bool_q;
    assign s1_valid   = s1_valid_q;
    assign pipe_valid = pv_q;
    assign final_flag = final_flag_q;
    assign err_nsyms  = err_q;
    assign busy       = (state_q != SCH_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_stage_1_scheduler.sv
// Directed self-checking bench for stage_1_scheduler.
module tb_stage_1_scheduler;
    import enc_pkg::*;

    localparam int unsigned PD = 4;

    logic                    general_clk = 1'b0;
    logic                    reset       = 1'b0;
    logic                    in_valid    = 1'b0;
    logic                    in_ready;
    logic [RANGE_WIDTH-1:0]  in_fl       = '0;
    logic [RANGE_WIDTH-1:0]  in_fh       = '0;
    logic [SYMBOL_WIDTH-1:0] in_symbol   = '0;
    logic [NSYMS_WIDTH-1:0]  in_nsyms    = '0;
    logic                    in_bool     = 1'b0;
    logic                    in_last     = 1'b0;
    logic                    pipe_stall  = 1'b0;
    logic [RANGE_WIDTH-1:0]  s1_fl;
    logic [RANGE_WIDTH-1:0]  s1_fh;
    logic [SYMBOL_WIDTH-1:0] s1_symbol;
    logic [NSYMS_WIDTH-1:0]  s1_nsyms;
    logic                    s1_bool;
    logic                    s1_valid;
    logic [PD-1:0]           pipe_valid;
    logic                    final_flag;
    logic                    busy;
    logic                    err_nsyms;

    int total = 0;
    int bad   = 0;

    sym_pkt_t stim [8];
    sym_pkt_t obs  [8];
    int       obs_cnt;
    int       fin_cnt;
    logic     timed_out;

    stage_1_scheduler #(
        .FIFO_DEPTH (4),
        .PIPE_DEPTH (PD)
    ) dut (
        .general_clk (general_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fl       (in_fl),
        .in_fh       (in_fh),
        .in_symbol   (in_symbol),
        .in_nsyms    (in_nsyms),
        .in_bool     (in_bool),
        .in_last     (in_last),
        .pipe_stall  (pipe_stall),
        .s1_fl       (s1_fl),
        .s1_fh       (s1_fh),
        .s1_symbol   (s1_symbol),
        .s1_nsyms    (s1_nsyms),
        .s1_bool     (s1_bool),
        .s1_valid    (s1_valid),
        .pipe_valid  (pipe_valid),
        .final_flag  (final_flag),
        .busy        (busy),
        .err_nsyms   (err_nsyms)
    );

    always #5 general_clk = ~general_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic sym_pkt_t mk(input logic [RANGE_WIDTH-1:0] fl, input logic [RANGE_WIDTH-1:0] fh,
                                    input logic [SYMBOL_WIDTH-1:0] sym, input logic [NSYMS_WIDTH-1:0] ns,
                                    input logic b, input logic l);
        sym_pkt_t p;
        p.fl = fl; p.fh = fh; p.symbol = sym; p.nsyms = ns; p.is_bool = b; p.last = l;
        return p;
    endfunction

    task automatic step();
        @(posedge general_clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_fl = '0; in_fh = '0; in_symbol = '0;
        in_nsyms = '0; in_bool = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_pkt(input sym_pkt_t p);
        in_valid = 1'b1; in_fl = p.fl; in_fh = p.fh; in_symbol = p.symbol;
        in_nsyms = p.nsyms; in_bool = p.is_bool; in_last = p.last;
    endtask

    task automatic apply_reset();
        drive_idle();
        pipe_stall = 1'b0;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    // Push stim[first..n-1] with handshake, record issues and flush pulses until the flush has passed.
    task automatic run_stream(input int first, input int n);
        int   idx;
        int   post;
        logic rdy, vld;
        idx = first; post = 0; obs_cnt = 0; fin_cnt = 0; timed_out = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (idx < n) drive_pkt(stim[idx]); else drive_idle();
            rdy = in_ready; vld = in_valid;
            step();
            if (vld && rdy) idx++;
            if (s1_valid) begin
                if (obs_cnt < 8) begin
                    obs[obs_cnt] = mk(s1_fl, s1_fh, s1_symbol, s1_nsyms, s1_bool, 1'b0);
                end
                obs_cnt++;
            end
            if (final_flag) fin_cnt++;
            if (fin_cnt > 0) post++;
            if (post >= 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if (s1_valid !== 1'b0)   begin bad++; $display("FAIL rst_s1_valid: got %b want 0", s1_valid); end
        total++; if (s1_fl !== 16'h0)     begin bad++; $display("FAIL rst_s1_fl: got %h want 0", s1_fl); end
        total++; if (s1_nsyms !== 5'h0)   begin bad++; $display("FAIL rst_s1_nsyms: got %h want 0", s1_nsyms); end
        total++; if (pipe_valid !== 4'h0) begin bad++; $display("FAIL rst_pipe_valid: got %b want 0", pipe_valid); end
        total++; if (final_flag !== 1'b0) begin bad++; $display("FAIL rst_final: got %b want 0", final_flag); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (err_nsyms !== 1'b0)  begin bad++; $display("FAIL rst_err: got %b want 0", err_nsyms); end
        reset = 1'b1;
        step();
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rel_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        sym_pkt_t p;
        logic     exp_v, exp_f;
        logic [PD-1:0] exp_pv;
        p = mk(16'h8000, 16'h4000, 4'd1, 5'd4, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k < 3) begin
                p.last = (k == 2);
                drive_pkt(p);
            end else begin
                drive_idle();
            end
            step();
            exp_v  = (k >= 2) && (k <= 4);
            exp_f  = (k == 8);
            exp_pv = '0;
            for (int j = 0; j < PD; j++) begin
                if ((k - j >= 2) && (k - j <= 4)) exp_pv[j] = 1'b1;
            end
            total++; if (s1_valid !== exp_v)    begin bad++; $display("FAIL basic_s1_valid c%0d: got %b want %b", k, s1_valid, exp_v); end
            total++; if (final_flag !== exp_f)  begin bad++; $display("FAIL basic_final c%0d: got %b want %b", k, final_flag, exp_f); end
            total++; if (pipe_valid !== exp_pv) begin bad++; $display("FAIL basic_pipe_valid c%0d: got %b want %b", k, pipe_valid, exp_pv); end
            if (exp_v) begin
                total++;
                if (s1_fl !== 16'h8000 || s1_fh !== 16'h4000 || s1_symbol !== 4'd1 || s1_nsyms !== 5'd4 || s1_bool !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_payload c%0d: got fl=%h fh=%h sym=%0d ns=%0d b=%b want fl=8000 fh=4000 sym=1 ns=4 b=0",
                             k, s1_fl, s1_fh, s1_symbol, s1_nsyms, s1_bool);
                end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            stim[i] = mk(16'h1000 + 16'(i), 16'h2000 + 16'(i), 4'(i % 3), 5'd4, 1'b0, (i == 5));
        end
        pipe_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pkt(stim[i]);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_push%0d: got %b want 1", i, in_ready); end
            step();
            total++; if (s1_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_issue_push%0d: got %b want 0", i, s1_valid); end
        end
        drive_pkt(stim[4]);
        for (int c = 0; c < 3; c++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full c%0d: got in_ready=%b want 0", c, in_ready); end
            step();
            total++; if (s1_valid !== 1'b0) begin bad++; $display("FAIL b2b_stalled c%0d: got s1_valid=%b want 0", c, s1_valid); end
        end
        pipe_stall = 1'b0;
        run_stream(4, 6);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b_timeout: got %b want 0", timed_out); end
        total++; if (obs_cnt !== 6)      begin bad++; $display("FAIL b2b_count: got %0d want 6", obs_cnt); end
        total++; if (fin_cnt !== 1)      begin bad++; $display("FAIL b2b_final_count: got %0d want 1", fin_cnt); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs[i].fl !== stim[i].fl || obs[i].fh !== stim[i].fh || obs[i].symbol !== stim[i].symbol) begin
                bad++;
                $display("FAIL b2b_order%0d: got fl=%h fh=%h sym=%0d want fl=%h fh=%h sym=%0d",
                         i, obs[i].fl, obs[i].fh, obs[i].symbol, stim[i].fl, stim[i].fh, stim[i].symbol);
            end
        end
    endtask

    task automatic test_bad_nsyms();
        stim[0] = mk(16'h3000, 16'h0100, 4'd0,  5'd2,  1'b0, 1'b0);
        stim[1] = mk(16'h3001, 16'h0101, 4'd0,  5'd17, 1'b0, 1'b0);
        stim[2] = mk(16'h3002, 16'h0102, 4'd5,  5'd4,  1'b0, 1'b0);
        stim[3] = mk(16'h3003, 16'h0103, 4'd0,  5'd1,  1'b0, 1'b0);
        stim[4] = mk(16'h3004, 16'h0104, 4'd15, 5'd16, 1'b0, 1'b1);
        total++; if (err_nsyms !== 1'b0) begin bad++; $display("FAIL bad_err_pre: got %b want 0", err_nsyms); end
        run_stream(0, 5);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bad_timeout: got %b want 0", timed_out); end
        total++; if (obs_cnt !== 2)      begin bad++; $display("FAIL bad_count: got %0d want 2", obs_cnt); end
        total++; if (obs[0].fl !== 16'h3000 || obs[0].nsyms !== 5'd2) begin
            bad++; $display("FAIL bad_first_good: got fl=%h ns=%0d want fl=3000 ns=2", obs[0].fl, obs[0].nsyms); end
        total++; if (obs[1].fl !== 16'h3004 || obs[1].symbol !== 4'd15 || obs[1].nsyms !== 5'd16) begin
            bad++; $display("FAIL bad_second_good: got fl=%h sym=%0d ns=%0d want fl=3004 sym=15 ns=16",
                            obs[1].fl, obs[1].symbol, obs[1].nsyms); end
        total++; if (err_nsyms !== 1'b1) begin bad++; $display("FAIL bad_err_post: got %b want 1", err_nsyms); end
        total++; if (fin_cnt !== 1)      begin bad++; $display("FAIL bad_final_count: got %0d want 1", fin_cnt); end
    endtask

    task automatic test_bool();
        apply_reset();
        stim[0] = mk(16'h5555, 16'h1111, 4'd1, 5'd9, 1'b1, 1'b0);
        stim[1] = mk(16'h6666, 16'h2222, 4'd2, 5'd2, 1'b1, 1'b1);
        total++; if (err_nsyms !== 1'b0) begin bad++; $display("FAIL bool_err_pre: got %b want 0", err_nsyms); end
        run_stream(0, 2);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bool_timeout: got %b want 0", timed_out); end
        total++; if (obs_cnt !== 1)      begin bad++; $display("FAIL bool_count: got %0d want 1", obs_cnt); end
        total++; if (obs[0].nsyms !== 5'd2) begin bad++; $display("FAIL bool_nsyms: got %0d want 2", obs[0].nsyms); end
        total++; if (obs[0].is_bool !== 1'b1 || obs[0].symbol !== 4'd1 || obs[0].fl !== 16'h5555) begin
            bad++; $display("FAIL bool_payload: got b=%b sym=%0d fl=%h want b=1 sym=1 fl=5555",
                            obs[0].is_bool, obs[0].symbol, obs[0].fl); end
        total++; if (fin_cnt !== 1)      begin bad++; $display("FAIL bool_final_count: got %0d want 1 (dropped last)", fin_cnt); end
        total++; if (err_nsyms !== 1'b1) begin bad++; $display("FAIL bool_err_post: got %b want 1", err_nsyms); end
    endtask

    task automatic test_drain_stall();
        sym_pkt_t p;
        int       fins;
        logic     exp_v, exp_f;
        p = mk(16'h7777, 16'h0777, 4'd3, 5'd8, 1'b0, 1'b1);
        fins = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) drive_pkt(p); else drive_idle();
            pipe_stall = (k == 4) || (k == 5) || (k == 9);
            step();
            exp_v = (k == 2);
            exp_f = (k == 8);
            if (final_flag) fins++;
            total++; if (s1_valid !== exp_v)   begin bad++; $display("FAIL drain_s1_valid c%0d: got %b want %b", k, s1_valid, exp_v); end
            total++; if (final_flag !== exp_f) begin bad++; $display("FAIL drain_final c%0d: got %b want %b", k, final_flag, exp_f); end
            if (k == 5) begin
                total++; if (pipe_valid !== 4'b0010) begin bad++; $display("FAIL drain_frozen: got %b want 0010", pipe_valid); end
            end
        end
        pipe_stall = 1'b0;
        total++; if (fins !== 1)    begin bad++; $display("FAIL drain_pulses: got %0d want 1", fins); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_midstream();
        int vlds, fins;
        pipe_stall = 1'b1;
        drive_pkt(mk(16'h9000, 16'h0900, 4'd1, 5'd3, 1'b0, 1'b0));
        step();
        drive_pkt(mk(16'h9001, 16'h0901, 4'd2, 5'd3, 1'b0, 1'b1));
        step();
        drive_idle();
        step();
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        total++; if (s1_fl !== 16'h7777)  begin bad++; $display("FAIL mid_hold_pre: got %h want 7777", s1_fl); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        total++; if (s1_fl !== 16'h0 || s1_fh !== 16'h0 || s1_symbol !== 4'h0 || s1_nsyms !== 5'h0 || s1_bool !== 1'b0) begin
            bad++; $display("FAIL mid_s1_regs: got fl=%h fh=%h sym=%h ns=%h b=%b want all 0",
                            s1_fl, s1_fh, s1_symbol, s1_nsyms, s1_bool); end
        total++; if (s1_valid !== 1'b0 || pipe_valid !== 4'h0 || final_flag !== 1'b0) begin
            bad++; $display("FAIL mid_ctrl: got v=%b pv=%b f=%b want 0", s1_valid, pipe_valid, final_flag); end
        total++; if (busy !== 1'b0 || err_nsyms !== 1'b0) begin
            bad++; $display("FAIL mid_status: got busy=%b err=%b want 0", busy, err_nsyms); end
        step(); step();
        reset = 1'b1;
        pipe_stall = 1'b0;
        vlds = 0; fins = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (s1_valid) vlds++;
            if (final_flag) fins++;
        end
        total++; if (vlds !== 0)        begin bad++; $display("FAIL mid_no_issue: got %0d want 0", vlds); end
        total++; if (fins !== 0)        begin bad++; $display("FAIL mid_no_final: got %0d want 0", fins); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy_post: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_post: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_nsyms();
        test_bool();
        test_drain_stall();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
